// File: rtl/snd_mix4_if.sv
// ---------------------------------------------------------------------------
// snd_mix4_if -- sample bus of the four-channel mixer.
//
// Carries the sample clock enable, the four signed channels with their 4.4
// unsigned gains, and the mixed result with its clip flag.
//   master : drives cen, ch0..ch3, gain0..gain3; receives mixed, peak
//   slave  : the mixer side (inputs/outputs reversed)
// Parameters W0..W3 and WOUT must match those of the attached snd_mix4.
// ---------------------------------------------------------------------------
interface snd_mix4_if #(
    parameter int W0   = 16,
    parameter int W1   = 16,
    parameter int W2   = 16,
    parameter int W3   = 16,
    parameter int WOUT = 16
);
    logic                   cen;
    logic signed [W0-1:0]   ch0;
    logic signed [W1-1:0]   ch1;
    logic signed [W2-1:0]   ch2;
    logic signed [W3-1:0]   ch3;
    logic [7:0]             gain0;
    logic [7:0]             gain1;
    logic [7:0]             gain2;
    logic [7:0]             gain3;
    logic signed [WOUT-1:0] mixed;
    logic                   peak;

    modport master (
        output cen, ch0, ch1, ch2, ch3, gain0, gain1, gain2, gain3,
        input  mixed, peak
    );

    modport slave (
        input  cen, ch0, ch1, ch2, ch3, gain0, gain1, gain2, gain3,
        output mixed, peak
    );
endinterface

// File: rtl/snd_mix4.sv
// ---------------------------------------------------------------------------
// snd_mix4 -- four-channel signed audio mixer with 4.4 per-channel gain.
//
// Two clock-enabled stages:
//   stage 1 : sign-extend each channel, multiply by {1'b0,gain}, register
//             the full-precision products
//   stage 2 : sum with two guard bits, arithmetic shift right by 4,
//             saturate to WOUT bits, register mixed and the clip flag
// Data and gain sampled on cen tick n appear on mixed after tick n+1.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, clears both stages
//   bus    snd_mix4_if.slave: cen, ch0..ch3, gain0..gain3 in; mixed, peak out
//
// Optional build macro SND_MIX4_PEAK_HOLD_EN: peak is stretched for
// PEAK_HOLD cen ticks after the last clipped sample. Without it, peak is
// the clip flag of the value currently on mixed.
// ---------------------------------------------------------------------------
module snd_mix4 #(
    parameter int W0        = 16,
    parameter int W1        = 16,
    parameter int W2        = 16,
    parameter int W3        = 16,
    parameter int WOUT      = 16,
    parameter int PEAK_HOLD = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    snd_mix4_if.slave bus
);

    // common channel width, product width, and sum width (guard bits, and
    // at least one bit wider than the output so the saturation compare works)
    localparam int CW01 = (W0 > W1) ? W0 : W1;
    localparam int CW23 = (W2 > W3) ? W2 : W3;
    localparam int CW   = (CW01 > CW23) ? CW01 : CW23;
    localparam int PW   = CW + 9;
    localparam int SW   = (PW + 2 > WOUT + 1) ? PW + 2 : WOUT + 1;

    localparam logic signed [SW-1:0]   SAT_HI_S = {{(SW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
    localparam logic signed [SW-1:0]   SAT_LO_S = {{(SW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};
    localparam logic signed [WOUT-1:0] SAT_HI   = {1'b0, {(WOUT-1){1'b1}}};
    localparam logic signed [WOUT-1:0] SAT_LO   = {1'b1, {(WOUT-1){1'b0}}};

    // ---------------- stage 1: multiply ----------------
    logic signed [CW-1:0] ext  [4];
    logic signed [8:0]    gs   [4];
    logic signed [PW-1:0] p_d  [4];
    logic signed [PW-1:0] p_q  [4];

    assign ext[0] = CW'(bus.ch0);
    assign ext[1] = CW'(bus.ch1);
    assign ext[2] = CW'(bus.ch2);
    assign ext[3] = CW'(bus.ch3);

    // zero-extended to 9 bits so a gain of 0x80..0xFF is never negative
    assign gs[0] = $signed({1'b0, bus.gain0});
    assign gs[1] = $signed({1'b0, bus.gain1});
    assign gs[2] = $signed({1'b0, bus.gain2});
    assign gs[3] = $signed({1'b0, bus.gain3});

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            p_d[i] = PW'(ext[i]) * PW'(gs[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) p_q[i] <= '0;
        end else if (bus.cen) begin
            for (int i = 0; i < 4; i++) p_q[i] <= p_d[i];
        end
    end

    // ---------------- stage 2: sum, scale, saturate ----------------
    logic signed [SW-1:0]   sum_c;
    logic signed [SW-1:0]   scaled_c;
    logic signed [WOUT-1:0] mixed_d, mixed_q;
    logic                   clip_c;
    logic                   peak_d, peak_q;

    always_comb begin
        sum_c    = SW'(p_q[0]) + SW'(p_q[1]) + SW'(p_q[2]) + SW'(p_q[3]);
        // undo the 4 fractional gain bits; >>> floors toward -inf
        scaled_c = sum_c >>> 4;
        clip_c   = 1'b0;
        mixed_d  = scaled_c[WOUT-1:0];
        if (scaled_c > SAT_HI_S) begin
            mixed_d = SAT_HI;
            clip_c  = 1'b1;
        end else if (scaled_c < SAT_LO_S) begin
            mixed_d = SAT_LO;
            clip_c  = 1'b1;
        end
    end

`ifdef SND_MIX4_PEAK_HOLD_EN
    localparam int CNTW = $clog2(PEAK_HOLD + 1);

    logic [CNTW-1:0] cnt_d, cnt_q;

    // a clip reloads the counter, so peak covers the clipped tick plus
    // PEAK_HOLD-1 further ticks after the last clip
    always_comb begin
        cnt_d  = cnt_q;
        peak_d = 1'b0;
        if (clip_c) begin
            cnt_d  = CNTW'(PEAK_HOLD);
            peak_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNTW'(1);
            peak_d = (cnt_d != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= '0;
        else if (bus.cen) cnt_q <= cnt_d;
    end
`else
    logic unused_peak_hold;

    assign unused_peak_hold = (PEAK_HOLD != 0);
    assign peak_d           = clip_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mixed_q <= '0;
            peak_q  <= 1'b0;
        end else if (bus.cen) begin
            mixed_q <= mixed_d;
            peak_q  <= peak_d;
        end
    end

    assign bus.mixed = mixed_q;
    assign bus.peak  = peak_q;

endmodule

// File: tb/tb_snd_mix4.sv
// ---------------------------------------------------------------------------
// tb_snd_mix4 -- directed vectors with hand-computed results for snd_mix4.
// ch1 is built 10 bits wide to exercise the narrow-channel sign extension.
// ---------------------------------------------------------------------------
module tb_snd_mix4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    snd_mix4_if #(.W1(10)) bus ();

    snd_mix4 #(.W1(10), .PEAK_HOLD(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int c0, input int c1, input int c2, input int c3,
                          input logic [7:0] g0, input logic [7:0] g1,
                          input logic [7:0] g2, input logic [7:0] g3);
        bus.ch0   = 16'(c0);
        bus.ch1   = 10'(c1);
        bus.ch2   = 16'(c2);
        bus.ch3   = 16'(c3);
        bus.gain0 = g0;
        bus.gain1 = g1;
        bus.gain2 = g2;
        bus.gain3 = g3;
    endtask

    // one cen tick; outputs are stable from #1 after the edge
    task automatic tk();
        bus.cen = 1'b1;
        @(posedge clk);
        #1;
        bus.cen = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    // load a vector, run it through both stages, check both outputs
    task automatic vec(input string tag, input int c0, input int c1, input int c2,
                       input int c3, input logic [7:0] g0, input logic [7:0] g1,
                       input logic [7:0] g2, input logic [7:0] g3,
                       input int exp_mix, input int exp_pk);
        set_in(c0, c1, c2, c3, g0, g1, g2, g3);
        tk();
        tk();
        chk({tag, ".mixed"}, int'(bus.mixed), exp_mix);
        chk({tag, ".peak"}, int'(bus.peak), exp_pk);
    endtask

    initial begin
        bus.cen = 1'b0;
        set_in(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        #3;
        chk("rst.mixed", int'(bus.mixed), 0);
        chk("rst.peak", int'(bus.peak), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // unity: unchanged after a single tick, visible after the second
        set_in(1000, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        tk();
        chk("unity.1tick", int'(bus.mixed), 0);
        tk();
        chk("unity.mixed", int'(bus.mixed), 1000);
        chk("unity.peak", int'(bus.peak), 0);

        // cen low: state holds while inputs move
        for (int i = 0; i < 10; i++) begin
            set_in(i * 37 - 100, 5, -3000, 2, 8'hFF, 8'h40, 8'h20, 8'h11);
            @(posedge clk);
            #1;
            chk("cen0.mixed", int'(bus.mixed), 1000);
        end
        set_in(1000, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        tk();
        chk("cen0.resume", int'(bus.mixed), 1000);

        // positive clip, then recovery
        vec("posclip", 20000, 0, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00, 32767, 1);
        set_in(100, 0, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00);
        tk();
        tk();
        chk("recov.mixed", int'(bus.mixed), 200);
`ifdef SND_MIX4_PEAK_HOLD_EN
        chk("recov.peak", int'(bus.peak), 1);
`else
        chk("recov.peak", int'(bus.peak), 0);
`endif

        // asynchronous reset mid-stream while peak is high
        vec("negclip", -20000, 0, -20000, 0, 8'h10, 8'h00, 8'h10, 8'h00, -32768, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.mixed", int'(bus.mixed), 0);
        chk("arst.peak", int'(bus.peak), 0);
        #1 rst_n = 1'b1;

        vec("floor", -1, 0, 0, 0, 8'h08, 8'h00, 8'h00, 8'h00, -1, 0);
        vec("narrow.m1", 0, 10'h3FF, 0, 0, 8'h00, 8'h10, 8'h00, 8'h00, -1, 0);
        vec("narrow.max", 0, 10'h1FF, 0, 0, 8'h00, 8'h40, 8'h00, 8'h00, 2044, 0);
        // 1600 - 1600 + 2400 + 1785 = 4185 -> floor(4185/16) = 261
        vec("mix4", 100, -50, 300, 7, 8'h10, 8'h20, 8'h08, 8'hFF, 261, 0);
        vec("edge.hi", 32767, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00, 32767, 0);
        vec("edge.lo", -32768, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00, -32768, 0);
        vec("edge.hi1", 32767, 0, 1, 0, 8'h10, 8'h00, 8'h10, 8'h00, 32767, 1);
        do_reset();
        vec("edge.lo1", -32768, 0, -1, 0, 8'h10, 8'h00, 8'h10, 8'h00, -32768, 1);
        do_reset();
        vec("maxgain", -32768, -512, -32768, -32768, 8'hFF, 8'hFF, 8'hFF, 8'hFF, -32768, 1);
        do_reset();
        // gain change alone, same data: x0.5 then x2
        vec("gain.half", 3001, 0, 0, 0, 8'h08, 8'h00, 8'h00, 8'h00, 1500, 0);
        vec("gain.dbl", 3001, 0, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00, 6002, 0);

`ifdef SND_MIX4_PEAK_HOLD_EN
        // single clipped sample, then clean data
        do_reset();
        set_in(20000, 0, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00);
        tk();
        set_in(100, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        tk();
        chk("hold.clip", int'(bus.peak), 1);
        for (int i = 1; i < 4; i++) begin
            tk();
            chk("hold.on", int'(bus.peak), 1);
        end
        tk();
        chk("hold.off", int'(bus.peak), 0);
        chk("hold.mixed", int'(bus.mixed), 100);

        // a second clip during the hold restarts the count
        set_in(20000, 0, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00);
        tk();
        set_in(100, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        tk();
        tk();
        tk();
        set_in(20000, 0, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00);
        tk();
        chk("rest.cnt1", int'(bus.peak), 1);
        set_in(100, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        tk();
        chk("rest.clip", int'(bus.mixed), 32767);
        for (int i = 1; i < 4; i++) begin
            tk();
            chk("rest.on", int'(bus.peak), 1);
        end
        tk();
        chk("rest.off", int'(bus.peak), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
